// File: rtl/dummy_accelerator_varlat.sv
// Variable-latency dummy accelerator: in-order circular buffer of XOR/ADD results with countdowns.
// Optional perf counters (done_cnt_o, stall_cnt_o) enabled by defining DUMMY_ACC_PERF_CNT_EN.
module dummy_accelerator_varlat #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IMM_WIDTH = 11,
  parameter int unsigned LAT_WIDTH = 5,
  parameter int unsigned DEPTH     = 4,
  parameter type         TagType_t = logic
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH-1:0]     rs1_value_i,
  input  logic [IMM_WIDTH-1:0] imm_i,
  input  TagType_t             tag_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [WIDTH-1:0]     result_o,
  output TagType_t             tag_o,
  output logic                 busy_o
`ifdef DUMMY_ACC_PERF_CNT_EN
  ,
  output logic [31:0]          done_cnt_o,
  output logic [31:0]          stall_cnt_o
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0]     r_res [DEPTH];
  TagType_t             r_tag [DEPTH];
  logic [LAT_WIDTH-1:0] r_cd  [DEPTH];
  logic [DEPTH-1:0]     r_occ;
  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [CntW-1:0]      r_count;
  logic                 r_init;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [LAT_WIDTH-1:0] w_lat;
  logic [LAT_WIDTH-1:0] w_cd_init;
  logic [WIDTH-1:0]     w_zimm;
  logic [WIDTH-1:0]     w_op_res;
  logic [DEPTH-1:0]     w_occ_d;

  // DEPTH is a power of two, so the count MSB alone marks a full buffer
  assign w_full  = r_count[PtrW];
  assign w_empty = (r_count == '0);

  assign w_lat     = imm_i[LAT_WIDTH-1:0];
  assign w_cd_init = (w_lat == '0) ? '0 : w_lat - 1'b1;
  assign w_zimm    = {{(WIDTH-IMM_WIDTH){1'b0}}, imm_i};
  assign w_op_res  = imm_i[IMM_WIDTH-1] ? (rs1_value_i + w_zimm) : (rs1_value_i ^ w_zimm);

  // r_init holds ready_o low until the first edge after reset release
  assign ready_o = r_init && !w_full && !flush_i;
  assign valid_o = !w_empty && (r_cd[r_rd_ptr] == '0);
  assign busy_o  = !w_empty;
  assign w_push  = valid_i && ready_o;
  assign w_pop   = valid_o && ready_i && !flush_i;

  always_comb begin
    result_o = '0;
    tag_o    = '0;
    if (!w_empty) begin
      result_o = r_res[r_rd_ptr];
      tag_o    = r_tag[r_rd_ptr];
    end
  end

  always_comb begin
    w_occ_d = r_occ;
    if (w_pop)  w_occ_d[r_rd_ptr] = 1'b0;
    if (w_push) w_occ_d[r_wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_occ    <= '0;
      r_init   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_res[i] <= '0;
        r_tag[i] <= '0;
        r_cd[i]  <= '0;
      end
    end else begin
      r_init <= 1'b1;
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_occ    <= '0;
      end else begin
        // Countdowns run regardless of back-pressure
        for (int i = 0; i < DEPTH; i++) begin
          if (r_occ[i] && (r_cd[i] != '0)) r_cd[i] <= r_cd[i] - 1'b1;
        end
        if (w_push) begin
          r_res[r_wr_ptr] <= w_op_res;
          r_tag[r_wr_ptr] <= tag_i;
          r_cd[r_wr_ptr]  <= w_cd_init;
          r_wr_ptr        <= r_wr_ptr + 1'b1;
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + {{(CntW-1){1'b0}}, w_push} - {{(CntW-1){1'b0}}, w_pop};
        r_occ   <= w_occ_d;
      end
    end
  end

`ifdef DUMMY_ACC_PERF_CNT_EN
  logic [31:0] r_done_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_done_cnt  <= '0;
      r_stall_cnt <= '0;
    end else if (flush_i) begin
      r_done_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop)                r_done_cnt  <= r_done_cnt + 1'b1;
      if (valid_o && !ready_i)  r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign done_cnt_o  = r_done_cnt;
  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: doc/dummy_accelerator_varlat.md
DUMMY_ACCELERATOR_VARLAT -- requirements
Module: dummy_accelerator_varlat

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter IMM_WIDTH, default 11, immediate width (IMM_WIDTH < WIDTH).
REQ-003 SHALL have parameter LAT_WIDTH, default 5, latency field width (LAT_WIDTH < IMM_WIDTH).
REQ-004 SHALL have parameter DEPTH, default 4, in-flight slots, power of two, >= 2.
REQ-005 SHALL have parameter type TagType_t, default logic, opaque tag (rd/id).
REQ-006 SHALL have ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, reset, asynchronous, active-low.
- flush_i, in, 1, synchronous kill of all in-flight ops.
- valid_i, in, 1, request valid.
- ready_o, out, 1, request accepted when valid_i && ready_o.
- rs1_value_i, in, WIDTH, operand.
- imm_i, in, IMM_WIDTH, control immediate.
- tag_i, in, TagType_t, request tag.
- valid_o, out, 1, result valid.
- ready_i, in, 1, downstream accepts result.
- result_o, out, WIDTH, result.
- tag_o, out, TagType_t, tag of result.
- busy_o, out, 1, at least one slot occupied.

Function
REQ-007 SHALL decode L = imm_i[LAT_WIDTH-1:0]; L = 0 SHALL be treated as L = 1.
REQ-008 SHALL select op by imm_i[IMM_WIDTH-1]: 0 -> rs1 XOR zext(imm_i); 1 -> rs1 + zext(imm_i) mod 2^WIDTH.
REQ-009 SHALL compute the result at acceptance and store result, tag, countdown L-1 in a circular buffer of DEPTH slots.
REQ-010 SHALL decrement every occupied slot's countdown by 1 per cycle, saturating at 0, independent of ready_i.
REQ-011 SHALL assert valid_o iff buffer non-empty and head countdown == 0; result_o/tag_o SHALL show head contents.
REQ-012 SHALL complete in order: a short-latency op behind a long one waits for the head, never overtakes.
REQ-013 SHALL, for an op accepted in cycle c reaching head with empty queue ahead, assert valid_o first in cycle c+L.
REQ-014 SHALL pop head on valid_o && ready_i; with ready_i low, head contents SHALL stay stable and valid_o SHALL stay high.
REQ-015 SHALL drive ready_o = !full, with no combinational path from ready_i or valid_i; full + pop in same cycle does not accept.
REQ-016 SHALL support simultaneous push and pop when not full; occupancy unchanged, pointers both advance, wrap modulo DEPTH.
REQ-017 SHALL drive result_o = '0 and tag_o = '0 when empty.
REQ-018 SHALL, on flush_i, empty the buffer at the next edge, ignore valid_i and ready_i that cycle, and drive ready_o low during that cycle.
REQ-019 SHALL drive busy_o = !empty.

Reset
REQ-020 SHALL on rst_ni low asynchronously clear pointers, occupancy and countdowns: valid_o=0, ready_o=0 while in reset, busy_o=0, result_o='0, tag_o='0.
REQ-021 SHALL drive ready_o=1 from the first cycle after rst_ni deasserts; reset mid-operation SHALL discard all in-flight ops without emitting them.

Configuration
REQ-022 SHALL, with macro DUMMY_ACC_PERF_CNT_EN defined, add ports done_cnt_o (out, 32, results popped) and stall_cnt_o (out, 32, cycles with valid_o && !ready_i); both wrap, reset to 0, are cleared by flush_i.
REQ-023 SHALL, without DUMMY_ACC_PERF_CNT_EN, omit both ports and counters; all other behaviour SHALL be identical.

Verification
REQ-024 SHALL cover: accept rs1=0x0000_00F0, imm=0x003 (XOR, L=3) in cycle 0, ready_i=1 -> valid_o first in cycle 3, result_o=0x0000_00F3, then empty, busy_o=0.
REQ-025 SHALL cover: op A L=8 in cycle 0, op B L=1 in cycle 1 -> B not output before A; A valid in cycle 8, B valid in cycle 9, tags in order.
REQ-026 SHALL cover: DEPTH=4, ready_i=0, 5 back-to-back requests L=1 -> 4 accepted, ready_o=0 from cycle 4, head stable; ready_i=1 -> 4 pops in consecutive cycles, ready_o=1 after the first pop.
REQ-027 SHALL cover: imm=0x401 (ADD, L=1), rs1=0xFFFF_FFFF -> result_o=0x0000_0400 in the next cycle; imm=0x000 -> treated as L=1.
REQ-028 SHALL cover: 3 ops in flight, flush_i for 1 cycle -> valid_o=0, busy_o=0 next cycle, no flushed op ever emitted; rst_ni pulse mid-stream -> same result.
REQ-029 SHALL cover, with DUMMY_ACC_PERF_CNT_EN: 2 results, one held 3 cycles by ready_i=0 -> done_cnt_o=2, stall_cnt_o=3.
